// File: rtl/snn_pkg.sv
// snn_pkg
// Shared definitions for the SNN multilayer core and its weight store:
// default bus widths, the fixed addresses of the two weight words, the
// write-back arbitration state type and an address range helper.
package snn_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DW_DEF     = 8;

    // Packed weight words: {w1,w2} and {w3,w4}
    localparam int W12_ADDR = 0;
    localparam int W34_ADDR = 1;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_DEFER = 2'd1,
        WB_ACK   = 2'd2
    } wb_state_t;

    function automatic logic addr_in_range(input int addr, input int depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/snn_weight_regfile.sv
// snn_weight_regfile
// DEPTH x DW weight storage with one synchronous write port and two
// combinational read ports (read path and debug). Out-of-range writes are
// dropped and out-of-range reads return 0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   we, waddr, wdata    - write port
//   raddr / rdata       - read-path port (combinational)
//   dbg_addr / dbg_data - debug port (combinational)
import snn_pkg::*;

module snn_weight_regfile #(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          DW      = DW_DEF,
    parameter int          DEPTH   = 16,
    parameter logic [DW-1:0] RST_W12 = 8'h11,
    parameter logic [DW-1:0] RST_W34 = 8'h11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == W12_ADDR)
                    mem[i] <= RST_W12;
                else if (i == W34_ADDR)
                    mem[i] <= RST_W34;
                else
                    mem[i] <= '0;
            end
        end else if (we && addr_in_range(int'(waddr), DEPTH)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata    = '0;
        dbg_data = '0;
        if (addr_in_range(int'(raddr), DEPTH))
            rdata = mem[raddr[IDX_W-1:0]];
        if (addr_in_range(int'(dbg_addr), DEPTH))
            dbg_data = mem[dbg_addr[IDX_W-1:0]];
    end

endmodule

// File: rtl/snn_weight_store.sv
// snn_weight_store
// Weight memory for the SNN multilayer core. Serves the core's one-cycle
// read channel, arbitrates the learning write-back channel against host
// configuration writes (host wins; a colliding write-back is deferred), and
// counts committed write-backs (saturating at 255).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   w_req, w_addr                - read request / address
//   w_valid, w_data              - registered read response
//   wb_req, wb_addr, wb_wdata    - write-back request
//   wb_ack                       - write-back completion pulse
//   cfg_we, cfg_addr, cfg_wdata  - host write port
//   lock                         - discard (but still ack) write-backs
//   dbg_addr, dbg_data           - combinational debug read
//   wb_count                     - committed write-back count
import snn_pkg::*;

module snn_weight_store #(
    parameter int            ADDR_W  = ADDR_W_DEF,
    parameter int            DW      = DW_DEF,
    parameter int            DEPTH   = 16,
    parameter logic [DW-1:0] RST_W12 = 8'h11,
    parameter logic [DW-1:0] RST_W34 = 8'h11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DW-1:0]     wb_wdata,
    output logic              wb_ack,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DW-1:0]     cfg_wdata,
    input  logic              lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data,
    output logic [7:0]        wb_count
);

    wb_state_t         state, state_n;
    logic [ADDR_W-1:0] lat_addr;
    logic [DW-1:0]     lat_data;
    logic              latch_wb;
    logic              wb_commit;
    logic              wb_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [DW-1:0]     commit_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [DW-1:0]     rd_data;

    snn_weight_regfile #(
        .ADDR_W  (ADDR_W),
        .DW      (DW),
        .DEPTH   (DEPTH),
        .RST_W12 (RST_W12),
        .RST_W34 (RST_W34)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr    (w_addr),
        .rdata    (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_n     = state;
        latch_wb    = 1'b0;
        wb_commit   = 1'b0;
        commit_addr = wb_addr;
        commit_data = wb_wdata;
        rf_we       = 1'b0;
        rf_waddr    = cfg_addr;
        rf_wdata    = cfg_wdata;
        case (state)
            WB_IDLE: begin
                if (wb_req && !cfg_we) begin
                    wb_commit = 1'b1;
                    state_n   = WB_ACK;
                end else begin
                    rf_we = cfg_we;
                    if (wb_req) begin
                        latch_wb = 1'b1;
                        state_n  = WB_DEFER;
                    end
                end
            end
            WB_DEFER: begin
                if (!cfg_we) begin
                    wb_commit   = 1'b1;
                    commit_addr = lat_addr;
                    commit_data = lat_data;
                    state_n     = WB_ACK;
                end else begin
                    rf_we = 1'b1;
                end
            end
            WB_ACK: begin
                rf_we   = cfg_we;
                state_n = WB_IDLE;
            end
            default: state_n = WB_IDLE;
        endcase

        // lock is looked at on the commit edge, not when the request arrived
        wb_write = wb_commit && !lock && addr_in_range(int'(commit_addr), DEPTH);
        if (wb_write) begin
            rf_we    = 1'b1;
            rf_waddr = commit_addr;
            rf_wdata = commit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WB_IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            wb_ack   <= 1'b0;
            wb_count <= '0;
            w_valid  <= 1'b0;
            w_data   <= '0;
        end else begin
            state   <= state_n;
            wb_ack  <= (state_n == WB_ACK);
            w_valid <= w_req;
            // rd_data is sampled before this edge's write lands: read-before-write
            if (w_req)
                w_data <= rd_data;
            if (latch_wb) begin
                lat_addr <= wb_addr;
                lat_data <= wb_wdata;
            end
            if (wb_write && (wb_count != 8'hFF))
                wb_count <= wb_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_snn_weight_store.sv
// tb_snn_weight_store
// Directed bench for snn_weight_store. A DEPTH=16 instance (dut) carries the
// main sequence; a DEPTH=2 instance (dut2) exercises out-of-range addresses.
module tb_snn_weight_store;

    logic       clk = 1'b0;
    logic       rst;

    logic       w_req, wb_req, cfg_we, lock;
    logic [3:0] w_addr, wb_addr, cfg_addr, dbg_addr;
    logic [7:0] wb_wdata, cfg_wdata;
    logic       w_valid, wb_ack;
    logic [7:0] w_data, dbg_data, wb_count;

    logic       b_w_req, b_wb_req;
    logic [3:0] b_w_addr, b_wb_addr, b_dbg_addr;
    logic [7:0] b_wb_wdata;
    logic       b_w_valid, b_wb_ack;
    logic [7:0] b_w_data, b_dbg_data, b_wb_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    snn_weight_store #(.ADDR_W(4), .DW(8), .DEPTH(16), .RST_W12(8'h11), .RST_W34(8'h11)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_ack(wb_ack),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .lock(lock), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_count(wb_count)
    );

    snn_weight_store #(.ADDR_W(4), .DW(8), .DEPTH(2), .RST_W12(8'h11), .RST_W34(8'h11)) dut2 (
        .clk(clk), .rst(rst),
        .w_req(b_w_req), .w_addr(b_w_addr), .w_valid(b_w_valid), .w_data(b_w_data),
        .wb_req(b_wb_req), .wb_addr(b_wb_addr), .wb_wdata(b_wb_wdata), .wb_ack(b_wb_ack),
        .cfg_we(1'b0), .cfg_addr(4'd0), .cfg_wdata(8'd0),
        .lock(1'b0), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .wb_count(b_wb_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        w_req = 0; wb_req = 0; cfg_we = 0; lock = 0;
        w_addr = 0; wb_addr = 0; cfg_addr = 0; dbg_addr = 0;
        wb_wdata = 0; cfg_wdata = 0;
        b_w_req = 0; b_wb_req = 0; b_w_addr = 0; b_wb_addr = 0; b_dbg_addr = 0; b_wb_wdata = 0;
        step();
        step();
        rst = 1'b0;

        // reset defaults
        dbg_chk("rst_dbg0", 4'd0, 8'h11);
        dbg_chk("rst_dbg1", 4'd1, 8'h11);
        dbg_chk("rst_dbg5", 4'd5, 8'h00);
        chk("rst_count", 32'(wb_count), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_wb_ack", 32'(wb_ack), 32'd0);

        // read addr 1
        w_req = 1; w_addr = 4'd1;
        step();
        w_req = 0;
        chk("rd1_valid", 32'(w_valid), 32'd1);
        chk("rd1_data", 32'(w_data), 32'h11);
        step();
        chk("rd1_valid_drop", 32'(w_valid), 32'd0);

        // uncontended write-back addr 1 <= 2F
        wb_req = 1; wb_addr = 4'd1; wb_wdata = 8'h2F;
        step();
        wb_req = 0;
        chk("wb1_ack", 32'(wb_ack), 32'd1);
        chk("wb1_count", 32'(wb_count), 32'd1);
        dbg_chk("wb1_dbg", 4'd1, 8'h2F);
        step();
        chk("wb1_ack_drop", 32'(wb_ack), 32'd0);
        w_req = 1; w_addr = 4'd1;
        step();
        w_req = 0;
        chk("rd2_data", 32'(w_data), 32'h2F);

        // contention: cfg held 2 cycles with wb_req in the first
        cfg_we = 1; cfg_addr = 4'd1; cfg_wdata = 8'hA5;
        wb_req = 1; wb_addr = 4'd1; wb_wdata = 8'h3C;
        step();
        wb_req = 0;
        chk("ct_ack_t1", 32'(wb_ack), 32'd0);
        step();
        cfg_we = 0;
        chk("ct_ack_t2", 32'(wb_ack), 32'd0);
        dbg_chk("ct_dbg_cfg", 4'd1, 8'hA5);
        step();
        chk("ct_ack_t3", 32'(wb_ack), 32'd1);
        dbg_chk("ct_dbg_final", 4'd1, 8'h3C);
        chk("ct_count", 32'(wb_count), 32'd2);
        step();
        chk("ct_ack_drop", 32'(wb_ack), 32'd0);

        // same-edge read and write-back on addr 0
        w_req = 1; w_addr = 4'd0;
        wb_req = 1; wb_addr = 4'd0; wb_wdata = 8'h77;
        step();
        w_req = 0; wb_req = 0;
        chk("se_valid", 32'(w_valid), 32'd1);
        chk("se_old_data", 32'(w_data), 32'h11);
        chk("se_ack", 32'(wb_ack), 32'd1);
        step();
        w_req = 1; w_addr = 4'd0;
        step();
        w_req = 0;
        chk("se_new_data", 32'(w_data), 32'h77);

        // locked write-back: acked, discarded
        lock = 1; wb_req = 1; wb_addr = 4'd0; wb_wdata = 8'h55;
        step();
        wb_req = 0;
        chk("lk_ack", 32'(wb_ack), 32'd1);
        chk("lk_count", 32'(wb_count), 32'd3);
        dbg_chk("lk_dbg", 4'd0, 8'h77);
        step();

        // lock high at request, low at deferred commit: commits
        cfg_we = 1; cfg_addr = 4'd5; cfg_wdata = 8'h99;
        wb_req = 1; wb_addr = 4'd2; wb_wdata = 8'h42;
        step();
        cfg_we = 0; wb_req = 0; lock = 0;
        step();
        chk("lkc_ack", 32'(wb_ack), 32'd1);
        chk("lkc_count", 32'(wb_count), 32'd4);
        dbg_chk("lkc_dbg2", 4'd2, 8'h42);
        dbg_chk("lkc_dbg5", 4'd5, 8'h99);
        step();

        // out-of-range on DEPTH=2 instance
        b_wb_req = 1; b_wb_addr = 4'd3; b_wb_wdata = 8'h66;
        step();
        b_wb_req = 0;
        chk("oor_ack", 32'(b_wb_ack), 32'd1);
        chk("oor_count", 32'(b_wb_count), 32'd0);
        step();
        b_w_req = 1; b_w_addr = 4'd3;
        step();
        b_w_req = 0;
        chk("oor_rd_valid", 32'(b_w_valid), 32'd1);
        chk("oor_rd_data", 32'(b_w_data), 32'd0);
        b_dbg_addr = 4'd3;
        #1;
        chk("oor_dbg", 32'(b_dbg_data), 32'd0);
        b_wb_req = 1; b_wb_addr = 4'd1; b_wb_wdata = 8'h5A;
        step();
        b_wb_req = 0;
        chk("ir2_count", 32'(b_wb_count), 32'd1);
        b_dbg_addr = 4'd1;
        #1;
        chk("ir2_dbg", 32'(b_dbg_data), 32'h5A);
        step();

        // saturation: fresh reset then 256 write-backs
        rst = 1;
        step();
        rst = 0;
        chk("sat_start", 32'(wb_count), 32'd0);
        for (int i = 0; i < 254; i++) begin
            wb_req = 1; wb_addr = 4'd3; wb_wdata = 8'(i);
            step();
            wb_req = 0;
            step();
        end
        chk("sat_254", 32'(wb_count), 32'd254);
        wb_req = 1; wb_wdata = 8'hFE;
        step();
        wb_req = 0;
        step();
        chk("sat_255", 32'(wb_count), 32'd255);
        wb_req = 1; wb_wdata = 8'hFF;
        step();
        wb_req = 0;
        chk("sat_hold_ack", 32'(wb_ack), 32'd1);
        step();
        chk("sat_hold", 32'(wb_count), 32'd255);
        dbg_chk("sat_dbg3", 4'd3, 8'hFF);

        // reset in the cycle after a contended wb_req
        cfg_we = 1; cfg_addr = 4'd4; cfg_wdata = 8'hEE;
        wb_req = 1; wb_addr = 4'd0; wb_wdata = 8'h88;
        step();
        cfg_we = 0; wb_req = 0; rst = 1;
        step();
        rst = 0;
        chk("mr_ack0", 32'(wb_ack), 32'd0);
        chk("mr_count", 32'(wb_count), 32'd0);
        dbg_chk("mr_dbg4", 4'd4, 8'h00);
        dbg_chk("mr_dbg3", 4'd3, 8'h00);
        step();
        chk("mr_ack1", 32'(wb_ack), 32'd0);
        step();
        chk("mr_ack2", 32'(wb_ack), 32'd0);
        dbg_chk("mr_dbg0", 4'd0, 8'h11);
        chk("mr_count_end", 32'(wb_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
